// File: rtl/line_refill_ctrl.sv
`default_nettype none
// line_refill_ctrl: refills one cache line from word-wide main memory, one word read at a time.
// Build option LINE_REFILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missed word.
module line_refill_ctrl #(
  parameter  int NrWordsPerLine = 4,
  localparam int LineSize       = 32 * NrWordsPerLine
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                mem_read_en_i,
  input  logic [31:0]         mem_addr_i,
  output logic                mem_read_valid_o,
  output logic [LineSize-1:0] mem_read_data_o,
  output logic                busy_o,
  output logic                word_req_o,
  output logic [31:0]         word_addr_o,
  input  logic                word_valid_i,
  input  logic [31:0]         word_data_i
);

  // Needs at least two words per line so idx/cnt are non-empty.
  localparam int IdxW = $clog2(NrWordsPerLine);
  localparam int OffW = IdxW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [31:OffW]      base;
  logic [IdxW-1:0]     idx;
  logic [IdxW-1:0]     cnt;
  logic [IdxW-1:0]     start_idx;
  logic [LineSize-1:0] line_buf;
  logic                last_word;

`ifdef LINE_REFILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = mem_addr_i[OffW-1:2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_i[1:0];
`else
  assign start_idx = '0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_i[OffW-1:0];
`endif

  assign last_word = (cnt == IdxW'(NrWordsPerLine - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_read_en_i) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (word_valid_i) state_next = last_word ? RESP : ISSUE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      base     <= '0;
      idx      <= '0;
      cnt      <= '0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read_en_i) begin
            base <= mem_addr_i[31:OffW];
            idx  <= start_idx;
            cnt  <= '0;
          end
        end
        WAIT: begin
          // Each word lands in its own slot regardless of fetch order.
          if (word_valid_i) begin
            line_buf[idx*32 +: 32] <= word_data_i;
            if (!last_word) begin
              cnt <= cnt + 1'b1;
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o           = (state != IDLE);
  assign word_req_o       = (state == ISSUE);
  assign word_addr_o      = (state == ISSUE) ? {base, idx, 2'b00} : 32'd0;
  assign mem_read_valid_o = (state == RESP);
  assign mem_read_data_o  = line_buf;

endmodule
`default_nettype wire

// File: tb/tb_line_refill_ctrl.sv
`default_nettype none
// tb_line_refill_ctrl: directed and randomized refills checked against a line-level reference model.
module tb_line_refill_ctrl;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         mem_read_en_i;
  logic [31:0]  mem_addr_i;
  logic         mem_read_valid_o;
  logic [127:0] mem_read_data_o;
  logic         busy_o;
  logic         word_req_o;
  logic [31:0]  word_addr_o;
  logic         word_valid_i;
  logic [31:0]  word_data_i;

  int compared   = 0;
  int mismatched = 0;

  int          lat_q[4];
  int          n_req;
  int          pend_cnt;
  logic [31:0] pend_addr;

  line_refill_ctrl #(.NrWordsPerLine(4)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .mem_read_en_i   (mem_read_en_i),
    .mem_addr_i      (mem_addr_i),
    .mem_read_valid_o(mem_read_valid_o),
    .mem_read_data_o (mem_read_data_o),
    .busy_o          (busy_o),
    .word_req_o      (word_req_o),
    .word_addr_o     (word_addr_o),
    .word_valid_i    (word_valid_i),
    .word_data_i     (word_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: answers each word request after its latency with addr+salt.
  task automatic mem_tick(input bit spurious, input logic [31:0] salt);
    word_valid_i = 1'b0;
    word_data_i  = 32'd0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        word_valid_i = 1'b1;
        word_data_i  = pend_addr + salt;
      end
    end
    if (word_req_o) begin
      pend_cnt  = lat_q[n_req & 3];
      pend_addr = word_addr_o;
      if (spurious) begin
        word_valid_i = 1'b1;
        word_data_i  = 32'hBAD0_0000 ^ salt;
      end
    end
  endtask

  // Called at a negedge in an IDLE cycle (cycle 0); returns at the first IDLE negedge after the pulse.
  task automatic run_refill(input logic [31:0] addr, input bit hold, input bit spurious,
                            input logic [31:0] salt);
    logic [31:0]  base;
    logic [31:0]  got_addr[4];
    logic [127:0] line;
    logic [127:0] exp_line;
    int start, cyc, vcyc, nvalid, exp_cyc, bad_addr, first_req_cyc;
    bit done;
    base = {addr[31:4], 4'h0};
`ifdef LINE_REFILL_CRITICAL_WORD_FIRST_EN
    start = int'(addr[3:2]);
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++) got_addr[k] = 32'hFFFF_FFFF;
    line = '0; cyc = 0; vcyc = -1; nvalid = 0; bad_addr = 0; first_req_cyc = -1; done = 0;
    n_req = 0; pend_cnt = 0;
    chk("idle_before_req", {127'd0, busy_o}, 128'd0);
    mem_read_en_i = 1'b1;
    mem_addr_i    = addr;
    while (!done && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (!hold) begin
        mem_read_en_i = 1'b0;
        mem_addr_i    = $urandom;
      end
      if (word_req_o && n_req < 4) got_addr[n_req] = word_addr_o;
      if (word_req_o && n_req == 0) first_req_cyc = cyc;
      if (!word_req_o && word_addr_o != 32'd0) bad_addr++;
      mem_tick(spurious, salt);
      if (word_req_o) n_req++;
      if (mem_read_valid_o) begin
        nvalid++;
        vcyc = cyc;
        line = mem_read_data_o;
        if (spurious) begin
          word_valid_i = 1'b1;
          word_data_i  = 32'hDEAD_0000 ^ salt;
        end
      end
      if (nvalid > 0 && !busy_o) done = 1;
    end
    exp_cyc = 1;
    for (int k = 0; k < 4; k++) exp_cyc += lat_q[k] + 1;
    for (int j = 0; j < 4; j++) exp_line[32*j +: 32] = base + 32'(4*j) + salt;
    chk("refill_done", {127'd0, done}, 128'd1);
    chk("word_req_count", 128'(n_req), 128'd4);
    chk("first_req_cycle", 128'(first_req_cyc), 128'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("word_addr_%0d", k), {96'd0, got_addr[k]},
          {96'd0, base + 32'(4*((start + k) % 4))});
    chk("valid_cycle", 128'(vcyc), 128'(exp_cyc));
    chk("valid_pulses", 128'(nvalid), 128'd1);
    chk("line_at_valid", line, exp_line);
    chk("line_held_after", mem_read_data_o, exp_line);
    chk("addr_zero_off_issue", 128'(bad_addr), 128'd0);
  endtask

  initial begin
    int bad;
    rstn_i = 1'b0; mem_read_en_i = 1'b0; mem_addr_i = 32'd0;
    word_valid_i = 1'b0; word_data_i = 32'd0;
    n_req = 0; pend_cnt = 0; pend_addr = 32'd0;

    // Reset and idle
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      chk("rst_valid", {127'd0, mem_read_valid_o}, 128'd0);
      chk("rst_data", mem_read_data_o, 128'd0);
      chk("rst_busy_req_addr", {94'd0, busy_o, word_req_o, word_addr_o}, 128'd0);
    end
    rstn_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      if (word_req_o || busy_o || mem_read_valid_o) bad++;
    end
    chk("idle_quiet", 128'(bad), 128'd0);

    // Basic refill, L=1
    lat_q = '{1, 1, 1, 1};
    run_refill(32'h0000_1234, 1'b0, 1'b0, 32'h0000_1000);
    chk("basic_line", mem_read_data_o,
        {32'h0000_223C, 32'h0000_2238, 32'h0000_2234, 32'h0000_2230});

    // Variable latency
    lat_q = '{3, 1, 5, 2};
    run_refill(32'h8000_0ABC, 1'b0, 1'b0, 32'h1357_0000);

    // Critical word first address pattern (order depends on build)
    lat_q = '{2, 2, 1, 3};
    run_refill(32'h0000_0048, 1'b0, 1'b0, 32'h0000_0100);

    // Request held high plus stray returns: refills run strictly back to back
    lat_q = '{2, 1, 3, 1};
    run_refill(32'h0000_5008, 1'b1, 1'b1, 32'h0A00_0000);
    run_refill(32'h0000_6004, 1'b1, 1'b1, 32'h0B00_0000);
    mem_read_en_i = 1'b0;
    word_valid_i  = 1'b0;
    @(negedge clk_i);
    chk("no_third_refill", {126'd0, busy_o, word_req_o}, 128'd0);

    // Randomized refills
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) lat_q[k] = int'($urandom_range(1, 5));
      run_refill($urandom, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset during the wait for the second word; the late word must be ignored
    lat_q = '{2, 2, 2, 2};
    n_req = 0; pend_cnt = 0;
    mem_read_en_i = 1'b1;
    mem_addr_i    = 32'h0000_7770;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      mem_read_en_i = 1'b0;
      if (n_req == 2 && !word_req_o) break;
      mem_tick(1'b0, 32'h0);
      if (word_req_o) n_req++;
    end
    chk("mid_reset_reached_wait2", {126'd0, busy_o, word_req_o}, 128'd2);
    rstn_i = 1'b0; word_valid_i = 1'b0; pend_cnt = 0;
    @(negedge clk_i);
    chk("mid_reset_busy", {127'd0, busy_o}, 128'd0);
    chk("mid_reset_data", mem_read_data_o, 128'd0);
    rstn_i       = 1'b1;
    word_valid_i = 1'b1;
    word_data_i  = 32'hCAFE_F00D;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      word_valid_i = 1'b0;
      if (mem_read_valid_o || busy_o || word_req_o || word_addr_o != 32'd0) bad++;
    end
    chk("post_reset_quiet", 128'(bad), 128'd0);
    chk("post_reset_data", mem_read_data_o, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
